// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - pipelined instruction fetch with PC-tagged response queue
module if_fetch_queue #(
    parameter int              PC_L          = 32,
    parameter int              INST_L        = 32,
    parameter int              QDEPTH        = 4,
    parameter logic [PC_L-1:0] PC_ENTRY      = 32'h00000000,
    parameter bit              STALL_ON_CTRL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_e,
    input  logic [PC_L-1:0]   redirect_pc,
    input  logic              resume_e,
    output logic              m_req_v,
    input  logic              m_req_rdy,
    output logic [PC_L-1:0]   m_addr,
    output logic [1:0]        m_rlen,
    input  logic              m_resp_v,
    input  logic [INST_L-1:0] m_resp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_L-1:0] out_inst,
    output logic [PC_L-1:0]   out_pc,
    output logic              ctrl_stall,
    output logic              halted
);

    // Pointer width for the power-of-two ring; counters must reach QDEPTH itself.
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(QDEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);
    localparam logic [6:0]    OP_JAL    = 7'b1101111;
    localparam logic [6:0]    OP_JALR   = 7'b1100111;
    localparam logic [6:0]    OP_BRANCH = 7'b1100011;

    logic [PC_L-1:0]   fetch_pc;
    logic [PC_L-1:0]   resp_pc;
    logic [CW-1:0]     count;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     drop_cnt;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic              ctrl_stall_q;
    logic              halted_q;

    logic [INST_L-1:0] inst_mem [QDEPTH];
    logic [PC_L-1:0]   pc_mem   [QDEPTH];

    logic [CW:0]       occupancy;
    logic              issue;
    logic              resp_live;
    logic              resp_zero;
    logic              enq;
    logic              deq;
    logic              is_ctrl;
    logic [CW-1:0]     inflight_next;

    // Queue slots plus outstanding reads never exceed QDEPTH, so every live response has room.
    assign occupancy = {1'b0, count} + {1'b0, inflight};
    assign m_req_v   = !redirect_e && !ctrl_stall_q && !halted_q && (occupancy < DEPTH_W);
    assign issue     = m_req_v && m_req_rdy;

    // Responses are stale while drop_cnt is nonzero, after a halt, or in a redirect cycle.
    assign resp_live = m_resp_v && !redirect_e && (drop_cnt == '0) && !halted_q;
    assign resp_zero = resp_live && (m_resp_data == '0);
    assign enq       = resp_live && (m_resp_data != '0);
    assign is_ctrl   = (m_resp_data[6:0] == OP_JAL) || (m_resp_data[6:0] == OP_JALR)
                    || (m_resp_data[6:0] == OP_BRANCH);

    assign out_valid = (count != '0) && !redirect_e;
    assign deq       = out_valid && out_ready;

    // Redirect cycles never issue, so this is also the count of reads left to discard.
    assign inflight_next = inflight + CW'(issue) - CW'(m_resp_v);

    assign m_addr     = fetch_pc;
    assign m_rlen     = 2'd3;
    assign out_inst   = (count != '0) ? inst_mem[rd_ptr] : '0;
    assign out_pc     = (count != '0) ? pc_mem[rd_ptr] : '0;
    assign ctrl_stall = ctrl_stall_q;
    assign halted     = halted_q;

    // Fetch/response bookkeeping; redirect overrides everything else in its cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc     <= PC_ENTRY;
            resp_pc      <= PC_ENTRY;
            count        <= '0;
            inflight     <= '0;
            drop_cnt     <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            ctrl_stall_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            inflight <= inflight_next;
            if (redirect_e) begin
                fetch_pc     <= redirect_pc;
                resp_pc      <= redirect_pc;
                count        <= '0;
                rd_ptr       <= '0;
                wr_ptr       <= '0;
                drop_cnt     <= inflight_next;
                ctrl_stall_q <= 1'b0;
                halted_q     <= 1'b0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + PC_L'(4);
                end
                if (m_resp_v && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                if (resp_zero) begin
                    halted_q <= 1'b1;
                end
                if (enq) begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    resp_pc <= resp_pc + PC_L'(4);
                end
                if (deq) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (enq && !deq) begin
                    count <= count + 1'b1;
                end else if (!enq && deq) begin
                    count <= count - 1'b1;
                end
                // A freshly enqueued control instruction wins over a same-cycle resume.
                if (enq && STALL_ON_CTRL && is_ctrl) begin
                    ctrl_stall_q <= 1'b1;
                end else if (resume_e) begin
                    ctrl_stall_q <= 1'b0;
                end
            end
        end
    end

    // Queue payload storage; validity is tracked by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem[wr_ptr] <= m_resp_data;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

    // Issue gating must make an enqueue into a full queue unreachable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!enq || (count < DEPTH_C));
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed table and sequence bench for if_fetch_queue
module tb_if_fetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect_e;
    logic [31:0] redirect_pc;
    logic        resume_e;
    logic        m_req_v;
    logic        m_req_rdy;
    logic [31:0] m_addr;
    logic [1:0]  m_rlen;
    logic        m_resp_v;
    logic [31:0] m_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        ctrl_stall;
    logic        halted;

    if_fetch_queue #(
        .PC_L          (32),
        .INST_L        (32),
        .QDEPTH        (4),
        .PC_ENTRY      (32'h00000000),
        .STALL_ON_CTRL (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect_e  (redirect_e),
        .redirect_pc (redirect_pc),
        .resume_e    (resume_e),
        .m_req_v     (m_req_v),
        .m_req_rdy   (m_req_rdy),
        .m_addr      (m_addr),
        .m_rlen      (m_rlen),
        .m_resp_v    (m_resp_v),
        .m_resp_data (m_resp_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .ctrl_stall  (ctrl_stall),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    typedef struct {
        bit          rst_before;
        bit          ready;
        bit          exp_req_v;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    req_t        pend[$];
    logic [31:0] mem_ovr [logic [31:0]];
    vec_t        vecs [18];
    int          cyc;
    int          lat;
    int          checks;
    int          failures;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ADDI x1,x1,addr[11:0] by default, so every word is nonzero and address-tagged.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (mem_ovr.exists(addr)) return mem_ovr[addr];
        return {addr[11:0], 5'd1, 3'b000, 5'd1, 7'b0010011};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_head(input string name, input logic [31:0] pc);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_pc"}, out_pc, pc);
        chk({name, "_inst"}, out_inst, mem_word(pc));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_e = 1'b0;
        redirect_pc = '0;
        resume_e = 1'b0;
        out_ready = 1'b0;
        m_req_rdy = 1'b0;
        m_resp_v = 1'b0;
        m_resp_data = '0;
        pend.delete();
        mem_ovr.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    // Record an accepted request, cross the edge, then present any response due this cycle.
    task automatic tick();
        #1;
        if (m_req_v && m_req_rdy) pend.push_back('{addr: m_addr, due: cyc + lat});
        @(posedge clk);
        cyc++;
        #1;
        redirect_e = 1'b0;
        resume_e = 1'b0;
        m_resp_v = 1'b0;
        m_resp_data = '0;
        if (pend.size() != 0 && pend[0].due == cyc) begin
            m_resp_v = 1'b1;
            m_resp_data = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        lat = 1;

        // Rows 0-4: streaming with out_ready=1; rows 5-17: backpressure fill then drain.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14};

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].rst_before) begin
                do_reset();
                lat = 1;
                #1;
                chk("rst_ctrl_stall", 32'(ctrl_stall), 32'd0);
                chk("rst_halted", 32'(halted), 32'd0);
                chk("rst_out_inst", out_inst, 32'd0);
                chk("rst_m_rlen", 32'(m_rlen), 32'd3);
            end
            out_ready = vecs[i].ready;
            m_req_rdy = 1'b1;
            #1;
            chk($sformatf("v%0d_req_v", i), 32'(m_req_v), 32'(vecs[i].exp_req_v));
            chk($sformatf("v%0d_addr", i), m_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_pc", i), out_pc, vecs[i].exp_pc);
            chk($sformatf("v%0d_inst", i), out_inst,
                vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : 32'd0);
            tick();
        end

        // BRANCH at 0x8 holds fetch; the 0xC read already in flight still lands; resume restarts at 0x10.
        do_reset();
        lat = 1;
        mem_ovr[32'h08] = 32'h00000063;
        for (int c = 0; c < 10; c++) begin
            out_ready = 1'b1;
            m_req_rdy = 1'b1;
            resume_e = (c == 6);
            #1;
            case (c)
                4: begin
                    chk("br_stall_c4", 32'(ctrl_stall), 32'd1);
                    chk("br_req_v_c4", 32'(m_req_v), 32'd0);
                    chk_head("br_head_c4", 32'h08);
                end
                5: begin
                    chk("br_stall_c5", 32'(ctrl_stall), 32'd1);
                    chk("br_req_v_c5", 32'(m_req_v), 32'd0);
                    chk_head("br_head_c5", 32'h0C);
                end
                6: begin
                    chk("br_valid_c6", 32'(out_valid), 32'd0);
                    chk("br_req_v_c6", 32'(m_req_v), 32'd0);
                end
                7: begin
                    chk("br_stall_c7", 32'(ctrl_stall), 32'd0);
                    chk("br_req_v_c7", 32'(m_req_v), 32'd1);
                    chk("br_addr_c7", m_addr, 32'h10);
                end
                9: chk_head("br_head_c9", 32'h10);
                default: ;
            endcase
            tick();
        end

        // Latency 3: two words queued, two reads in flight, redirect flushes and drops both.
        do_reset();
        lat = 3;
        for (int c = 0; c < 14; c++) begin
            m_req_rdy = (c <= 1) || (c >= 5);
            out_ready = (c >= 8);
            redirect_e = (c == 7);
            redirect_pc = 32'h1000;
            #1;
            case (c)
                6: chk_head("rd_head_c6", 32'h00);
                7: begin
                    chk("rd_valid_c7", 32'(out_valid), 32'd0);
                    chk("rd_req_v_c7", 32'(m_req_v), 32'd0);
                end
                8: begin
                    chk("rd_valid_c8", 32'(out_valid), 32'd0);
                    chk("rd_req_v_c8", 32'(m_req_v), 32'd1);
                    chk("rd_addr_c8", m_addr, 32'h1000);
                end
                9, 10, 11: chk($sformatf("rd_valid_c%0d", c), 32'(out_valid), 32'd0);
                12: chk_head("rd_head_c12", 32'h1000);
                13: chk_head("rd_head_c13", 32'h1004);
                default: ;
            endcase
            tick();
        end

        // Zero word at 0x14 halts fetch and is never delivered; redirect to 0 restarts.
        do_reset();
        lat = 1;
        mem_ovr[32'h14] = 32'h00000000;
        for (int c = 0; c < 13; c++) begin
            out_ready = 1'b1;
            m_req_rdy = 1'b1;
            redirect_e = (c == 9);
            redirect_pc = 32'h0;
            #1;
            case (c)
                6: begin
                    chk_head("hl_head_c6", 32'h10);
                    chk("hl_halted_c6", 32'(halted), 32'd0);
                end
                7: begin
                    chk("hl_halted_c7", 32'(halted), 32'd1);
                    chk("hl_req_v_c7", 32'(m_req_v), 32'd0);
                    chk("hl_valid_c7", 32'(out_valid), 32'd0);
                end
                8: begin
                    chk("hl_halted_c8", 32'(halted), 32'd1);
                    chk("hl_valid_c8", 32'(out_valid), 32'd0);
                end
                9: chk("hl_req_v_c9", 32'(m_req_v), 32'd0);
                10: begin
                    chk("hl_halted_c10", 32'(halted), 32'd0);
                    chk("hl_req_v_c10", 32'(m_req_v), 32'd1);
                    chk("hl_addr_c10", m_addr, 32'h0);
                end
                12: chk_head("hl_head_c12", 32'h0);
                default: ;
            endcase
            tick();
        end

        // JAL stalls; redirect with resume and a live response: that response and the last read are dropped.
        do_reset();
        lat = 3;
        mem_ovr[32'h00] = 32'h0000006F;
        for (int c = 0; c < 11; c++) begin
            out_ready = 1'b1;
            m_req_rdy = 1'b1;
            redirect_e = (c == 5);
            resume_e = (c == 5);
            redirect_pc = 32'h2000;
            #1;
            case (c)
                4: begin
                    chk("co_stall_c4", 32'(ctrl_stall), 32'd1);
                    chk("co_req_v_c4", 32'(m_req_v), 32'd0);
                    chk_head("co_head_c4", 32'h00);
                end
                5: begin
                    chk("co_resp_v_c5", 32'(m_resp_v), 32'd1);
                    chk("co_valid_c5", 32'(out_valid), 32'd0);
                    chk("co_req_v_c5", 32'(m_req_v), 32'd0);
                end
                6: begin
                    chk("co_stall_c6", 32'(ctrl_stall), 32'd0);
                    chk("co_req_v_c6", 32'(m_req_v), 32'd1);
                    chk("co_addr_c6", m_addr, 32'h2000);
                    chk("co_valid_c6", 32'(out_valid), 32'd0);
                end
                7, 8, 9: chk($sformatf("co_valid_c%0d", c), 32'(out_valid), 32'd0);
                10: chk_head("co_head_c10", 32'h2000);
                default: ;
            endcase
            tick();
        end

        // Asynchronous reset mid-operation clears state without waiting for an edge.
        rst = 1'b1;
        pend.delete();
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_addr", m_addr, 32'h0);
        chk("ar_out_pc", out_pc, 32'h0);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage for the RISCV32 pipeline. Replaces event-driven fetch with a fully synchronous front end: it issues pipelined reads to instruction memory, buffers returned instructions with their PCs in a QDEPTH-entry queue, and hands them to decode over a valid/ready handshake. Handles redirect (jump/branch resolve) with queue flush and stale-response discard. It optionally holds fetch after control-flow instructions until execute resolves them.

## Interface
- PC_L, 32, PC width
- INST_L, 32, instruction width
- QDEPTH, 4, queue entries (power of 2, ≥2); also bounds in-flight reads
- PC_ENTRY, 32'h00000000, fetch PC after reset
- STALL_ON_CTRL, 1, 1 = stop issuing after enqueuing JAL/JALR/BRANCH until redirect or resume
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- redirect_e  in  1  one-cycle pulse: flush, refetch from redirect_pc
- redirect_pc  in  PC_L  new fetch PC
- resume_e  in  1  one-cycle pulse: clear control stall, no flush (branch not taken)
- m_req_v  out  1  read request valid
- m_req_rdy  in  1  memory accepts request
- m_addr  out  PC_L  read address (= fetch_pc)
- m_rlen  out  2  constant 3 (word)
- m_resp_v  in  1  read data valid; responses return in request order
- m_resp_data  in  INST_L  read data
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_inst  out  INST_L  head instruction
- out_pc  out  PC_L  head PC
- ctrl_stall  out  1  fetch held on control instruction
- halted  out  1  all-zero instruction fetched; fetch stopped

## Operation
- State: fetch_pc, resp_pc, queue (count 0..QDEPTH, wrapping rd/wr pointers), inflight 0..QDEPTH, drop_cnt 0..QDEPTH, ctrl_stall, halted.
- m_req_v = !redirect_e && !ctrl_stall && !halted && (count + inflight < QDEPTH). Issue on m_req_v && m_req_rdy: fetch_pc += 4 (mod 2^PC_L), inflight += 1.
- Response (m_resp_v): inflight -= 1. If drop_cnt != 0: drop_cnt -= 1, discard. Else if halted: discard. Else if data == 0: halted <= 1, not enqueued. Else enqueue {resp_pc, data}, resp_pc += 4; if STALL_ON_CTRL and data[6:0] ∈ {1101111, 1100111, 1100011}: ctrl_stall <= 1.
- Issue gating guarantees no enqueue overflow; response with queue full is impossible and is an assertion failure.
- Dequeue on out_valid && out_ready. out_valid = count != 0 && !redirect_e. out_inst/out_pc driven from head entry (0 when empty).
- Redirect (highest priority): queue flushed (count 0), fetch_pc and resp_pc <= redirect_pc, ctrl_stall <= 0, halted <= 0, drop_cnt <= inflight_next, where inflight_next is inflight after this cycle's response (no issue in redirect cycle). Response arriving in the redirect cycle is discarded.
- resume_e: ctrl_stall <= 0; ignored if redirect_e in same cycle.

## Timing
- Reset values: fetch_pc = resp_pc = PC_ENTRY; count = inflight = drop_cnt = 0; ctrl_stall = halted = 0; m_req_v = 1 in first cycle with rst low and m_addr = PC_ENTRY; out_valid = 0; out_inst = out_pc = 0.
- Enqueued instruction visible on out_valid the cycle after m_resp_v (1-cycle latency); enqueue and dequeue in same cycle keep count.
- ctrl_stall asserts the cycle after the control response; m_req_v low from that cycle.
- After redirect, first new request issues the following cycle at redirect_pc.
- Reset mid-operation: all state cleared immediately; memory must also be reset (no stale-response tracking across reset).

## Test plan
- Reset, m_req_rdy=1, memory 1-cycle latency with ADDI words at 0x0,0x4,0x8, out_ready=1 -> out_pc 0x0,0x4,0x8 on consecutive cycles, out_inst matching.
- out_ready=0, QDEPTH=4 -> exactly 4 requests issued, count=4, m_req_v=0; release -> 4 in-order dequeues, then fetch resumes at 0x10.
- BRANCH at 0x8, STALL_ON_CTRL=1 -> ctrl_stall=1, no request past 0xC already in flight; resume_e -> fetching continues at next fetch_pc, no flush.
- Redirect to 0x1000 with 2 reads in flight (memory latency 3) -> both responses discarded, next out_pc = 0x1000, queue empty in redirect cycle.
- Response data 0 at 0x14 -> halted=1, m_req_v=0, 0x14 never on out_pc; redirect to 0x0 -> halted=0, fetch restarts.
- Redirect coincident with m_resp_v and resume_e -> response discarded, drop_cnt = remaining inflight, ctrl_stall=0.
